// File: rtl/ssriscv_ifu_pc_ctrl.sv
// Fetch-stage PC sequencer: picks the next PC, runs the single-outstanding imem
// handshake, buffers one instruction for decode and kills fetches made stale by redirects.
module ssriscv_ifu_pc_ctrl #(
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_rst,
  input  logic        trap_valid,
  input  logic [31:0] trap_pc,
  input  logic        ex_redirect_valid,
  input  logic [31:0] ex_redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  input  logic        if_ready,
  output logic        misalign_err
);

  typedef enum logic [1:0] {ST_RST, ST_REQ, ST_WAIT, ST_OUT} state_t;

  state_t      state, state_d;
  logic [31:0] pc, pc_d, if_pc_d, if_instr_d, tgt, tgt_al;
  logic        kill, kill_d, if_valid_d, mis_d, redir;

  always_comb begin
    state_d    = state;
    pc_d       = pc;
    kill_d     = kill;
    if_valid_d = if_valid;
    if_pc_d    = if_pc;
    if_instr_d = if_instr;
    imem_req   = (state == ST_REQ);
    imem_addr  = pc;
    // trap outranks the EX redirect; neither is honoured while resetting
    redir      = !rst && (state != ST_RST) && (trap_valid || ex_redirect_valid);
    tgt        = trap_valid ? trap_pc : ex_redirect_pc;
    tgt_al     = {tgt[31:2], 2'b00};
    mis_d      = redir && (tgt[1:0] != 2'b00);

    case (state)
      ST_RST: state_d = ST_REQ;
      ST_REQ: begin
        if (redir) pc_d = tgt_al;
        if (imem_gnt) begin
          state_d = ST_WAIT;
          kill_d  = redir;
        end
      end
      ST_WAIT: begin
        if (imem_rvalid) begin
          if (kill || redir) begin
            if (redir) pc_d = tgt_al;
            kill_d  = 1'b0;
            state_d = ST_REQ;
          end else begin
            if_valid_d = 1'b1;
            if_pc_d    = pc;
            if_instr_d = imem_rdata;
            state_d    = ST_OUT;
          end
        end else if (redir) begin
          pc_d   = tgt_al;
          kill_d = 1'b1;
        end
      end
      ST_OUT: begin
        // a redirect wins over pc+4 whether or not decode took the instruction
        if (redir || if_ready) begin
          pc_d       = redir ? tgt_al : pc + 32'd4;
          if_valid_d = 1'b0;
          if_instr_d = NOP_INSTR;
          state_d    = ST_REQ;
        end
      end
      default: state_d = ST_RST;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_RST;
      pc           <= {pc_rst[31:2], 2'b00};
      kill         <= 1'b0;
      if_valid     <= 1'b0;
      if_pc        <= 32'h0;
      if_instr     <= NOP_INSTR;
      misalign_err <= 1'b0;
    end else begin
      state        <= state_d;
      pc           <= pc_d;
      kill         <= kill_d;
      if_valid     <= if_valid_d;
      if_pc        <= if_pc_d;
      if_instr     <= if_instr_d;
      misalign_err <= mis_d;
    end
  end

endmodule

// File: tb/tb_ssriscv_ifu_pc_ctrl.sv
// Directed bench for ssriscv_ifu_pc_ctrl: per-cycle vector table plus hand sequences.
module tb_ssriscv_ifu_pc_ctrl;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst, trap_valid, ex_redirect_valid, imem_gnt, imem_rvalid, if_ready;
  logic [31:0] pc_rst, trap_pc, ex_redirect_pc, imem_rdata;
  logic        imem_req, if_valid, misalign_err;
  logic [31:0] imem_addr, if_pc, if_instr;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ssriscv_ifu_pc_ctrl #(.NOP_INSTR(NOP)) dut (
    .clk(clk), .rst(rst), .pc_rst(pc_rst),
    .trap_valid(trap_valid), .trap_pc(trap_pc),
    .ex_redirect_valid(ex_redirect_valid), .ex_redirect_pc(ex_redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr), .if_ready(if_ready),
    .misalign_err(misalign_err)
  );

  typedef struct {
    logic        rst, tv, ev, gnt, rv, rdy;
    logic [31:0] tpc, epc, rdata;
    logic        e_req, e_ifv, e_mis;
    logic [31:0] e_addr, e_ifpc, e_instr;
  } vec_t;

  vec_t tbl[$];

  // inputs applied this cycle, outputs expected before this cycle's edge
  function automatic vec_t mk(logic r, logic tv, logic [31:0] tpc, logic ev, logic [31:0] epc,
                              logic g, logic rv, logic [31:0] rd, logic rdy,
                              logic req, logic [31:0] addr, logic ifv, logic [31:0] ifpc,
                              logic [31:0] ins, logic mis);
    vec_t v;
    v.rst = r; v.tv = tv; v.tpc = tpc; v.ev = ev; v.epc = epc; v.gnt = g; v.rv = rv;
    v.rdata = rd; v.rdy = rdy; v.e_req = req; v.e_addr = addr; v.e_ifv = ifv;
    v.e_ifpc = ifpc; v.e_instr = ins; v.e_mis = mis;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_out(int idx, logic req, logic [31:0] addr, logic ifv,
                           logic [31:0] ifpc, logic [31:0] ins, logic mis);
    chk($sformatf("v%0d imem_req", idx), {31'h0, imem_req}, {31'h0, req});
    chk($sformatf("v%0d imem_addr", idx), imem_addr, addr);
    chk($sformatf("v%0d if_valid", idx), {31'h0, if_valid}, {31'h0, ifv});
    chk($sformatf("v%0d if_pc", idx), if_pc, ifpc);
    chk($sformatf("v%0d if_instr", idx), if_instr, ins);
    chk($sformatf("v%0d misalign_err", idx), {31'h0, misalign_err}, {31'h0, mis});
  endtask

  task automatic drive(logic r, logic tv, logic [31:0] tpc, logic ev, logic [31:0] epc,
                       logic g, logic rv, logic [31:0] rd, logic rdy);
    rst = r; trap_valid = tv; trap_pc = tpc; ex_redirect_valid = ev; ex_redirect_pc = epc;
    imem_gnt = g; imem_rvalid = rv; imem_rdata = rd; if_ready = rdy;
  endtask

  initial begin
    pc_rst = 32'h0000_1003;
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);

    //          rst tv tpc          ev epc          g  rv rdata         rdy  req addr          ifv ifpc          instr         mis
    tbl.push_back(mk(0, 0, 0,            0, 0,            0, 0, 0,            0,   0, 32'h1000,     0, 0,            NOP,          0));
    tbl.push_back(mk(0, 0, 0,            0, 0,            1, 0, 0,            0,   1, 32'h1000,     0, 0,            NOP,          0));
    tbl.push_back(mk(0, 0, 0,            0, 0,            0, 1, 32'h00A00093, 0,   0, 32'h1000,     0, 0,            NOP,          0));
    tbl.push_back(mk(0, 0, 0,            0, 0,            0, 0, 0,            1,   0, 32'h1000,     1, 32'h1000,     32'h00A00093, 0));
    tbl.push_back(mk(0, 0, 0,            0, 0,            0, 0, 0,            0,   1, 32'h1004,     0, 32'h1000,     NOP,          0));
    tbl.push_back(mk(0, 0, 0,            0, 0,            1, 0, 0,            0,   1, 32'h1004,     0, 32'h1000,     NOP,          0));
    tbl.push_back(mk(0, 0, 0,            0, 0,            0, 1, 32'h11111111, 0,   0, 32'h1004,     0, 32'h1000,     NOP,          0));
    for (int i = 0; i < 5; i++)
      tbl.push_back(mk(0, 0, 0,          0, 0,            0, 0, 0,            0,   0, 32'h1004,     1, 32'h1004,     32'h11111111, 0));
    tbl.push_back(mk(0, 0, 0,            0, 0,            0, 0, 0,            1,   0, 32'h1004,     1, 32'h1004,     32'h11111111, 0));
    tbl.push_back(mk(0, 0, 0,            0, 0,            1, 0, 0,            0,   1, 32'h1008,     0, 32'h1004,     NOP,          0));
    tbl.push_back(mk(0, 0, 0,            1, 32'h2000,     0, 0, 0,            0,   0, 32'h1008,     0, 32'h1004,     NOP,          0));
    tbl.push_back(mk(0, 0, 0,            0, 0,            0, 1, 32'h22222222, 0,   0, 32'h2000,     0, 32'h1004,     NOP,          0));
    tbl.push_back(mk(0, 0, 0,            0, 0,            0, 0, 0,            0,   1, 32'h2000,     0, 32'h1004,     NOP,          0));
    tbl.push_back(mk(0, 1, 32'h8000,     1, 32'h2000,     1, 0, 0,            0,   1, 32'h2000,     0, 32'h1004,     NOP,          0));
    tbl.push_back(mk(0, 0, 0,            0, 0,            0, 1, 32'h33333333, 0,   0, 32'h8000,     0, 32'h1004,     NOP,          0));
    tbl.push_back(mk(0, 0, 0,            0, 0,            1, 0, 0,            0,   1, 32'h8000,     0, 32'h1004,     NOP,          0));
    tbl.push_back(mk(0, 0, 0,            0, 0,            0, 1, 32'h44444444, 0,   0, 32'h8000,     0, 32'h1004,     NOP,          0));
    tbl.push_back(mk(0, 0, 0,            1, 32'h3002,     0, 0, 0,            1,   0, 32'h8000,     1, 32'h8000,     32'h44444444, 0));
    tbl.push_back(mk(0, 0, 0,            0, 0,            0, 0, 0,            0,   1, 32'h3000,     0, 32'h8000,     NOP,          1));
    tbl.push_back(mk(0, 0, 0,            0, 0,            1, 0, 0,            0,   1, 32'h3000,     0, 32'h8000,     NOP,          0));
    tbl.push_back(mk(0, 0, 0,            0, 0,            0, 1, 32'h55555555, 0,   0, 32'h3000,     0, 32'h8000,     NOP,          0));
    tbl.push_back(mk(0, 0, 0,            1, 32'hFFFFFFFC, 0, 0, 0,            0,   0, 32'h3000,     1, 32'h3000,     32'h55555555, 0));
    tbl.push_back(mk(0, 0, 0,            0, 0,            1, 0, 0,            0,   1, 32'hFFFFFFFC, 0, 32'h3000,     NOP,          0));
    tbl.push_back(mk(0, 0, 0,            0, 0,            0, 1, 32'h66666666, 0,   0, 32'hFFFFFFFC, 0, 32'h3000,     NOP,          0));
    tbl.push_back(mk(0, 0, 0,            0, 0,            0, 0, 0,            1,   0, 32'hFFFFFFFC, 1, 32'hFFFFFFFC, 32'h66666666, 0));
    tbl.push_back(mk(0, 0, 0,            0, 0,            1, 0, 0,            0,   1, 32'h0,        0, 32'hFFFFFFFC, NOP,          0));
    tbl.push_back(mk(1, 0, 0,            0, 0,            0, 0, 0,            0,   0, 32'h0,        0, 32'hFFFFFFFC, NOP,          0));
    tbl.push_back(mk(1, 0, 0,            1, 32'h5000,     0, 1, 32'h77777777, 0,   0, 32'h1000,     0, 0,            NOP,          0));
    tbl.push_back(mk(0, 0, 0,            0, 0,            0, 1, 32'h77777777, 0,   0, 32'h1000,     0, 0,            NOP,          0));
    tbl.push_back(mk(0, 0, 0,            0, 0,            0, 0, 0,            0,   1, 32'h1000,     0, 0,            NOP,          0));

    foreach (tbl[i]) begin
      @(negedge clk);
      check_out(i, tbl[i].e_req, tbl[i].e_addr, tbl[i].e_ifv, tbl[i].e_ifpc, tbl[i].e_instr, tbl[i].e_mis);
      drive(tbl[i].rst, tbl[i].tv, tbl[i].tpc, tbl[i].ev, tbl[i].epc,
            tbl[i].gnt, tbl[i].rv, tbl[i].rdata, tbl[i].rdy);
    end

    // Hand sequence: new reset vector, trap redirect while REQ is not granted
    @(negedge clk);
    pc_rst = 32'h0000_ABCF;
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("h1 req_after_reset", {31'h0, imem_req}, 32'h1);
    chk("h1 addr_after_reset", imem_addr, 32'h0000_ABCC);
    drive(0, 1, 32'h0000_0501, 1, 32'h0000_0900, 0, 0, 0, 0);
    @(negedge clk);
    chk("h1 req_held", {31'h0, imem_req}, 32'h1);
    chk("h1 addr_redirected", imem_addr, 32'h0000_0500);
    chk("h1 mis_pulse", {31'h0, misalign_err}, 32'h1);
    drive(0, 0, 0, 0, 0, 1, 0, 0, 0);
    @(negedge clk);
    chk("h1 mis_cleared", {31'h0, misalign_err}, 32'h0);
    chk("h1 wait_no_req", {31'h0, imem_req}, 32'h0);

    // Hand sequence: redirect in WAIT coincident with rvalid drops that response
    drive(0, 0, 0, 1, 32'h0000_0C00, 0, 1, 32'hDEADBEEF, 0);
    @(negedge clk);
    chk("h2 dropped_if_valid", {31'h0, if_valid}, 32'h0);
    chk("h2 req_again", {31'h0, imem_req}, 32'h1);
    chk("h2 addr_redirect", imem_addr, 32'h0000_0C00);
    drive(0, 0, 0, 0, 0, 1, 0, 0, 0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 1, 32'hCAFEF00D, 0);
    @(negedge clk);
    chk("h2 fetched_valid", {31'h0, if_valid}, 32'h1);
    chk("h2 fetched_pc", if_pc, 32'h0000_0C00);
    chk("h2 fetched_instr", if_instr, 32'hCAFEF00D);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
    @(negedge clk);
    chk("h2 consumed_addr", imem_addr, 32'h0000_0C04);
    chk("h2 instr_nop", if_instr, NOP);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
